// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake and Z/N/C/V flags.
// Define ALU_PIPE_SAT_EN to saturate ADD/SUB results on signed overflow.
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpPass = 3'b111;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_load;
  logic             s2_load;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [SHW-1:0]   shamt;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;

  // S1 may also refill in the cycle it hands its beat on to S2.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;

  assign shamt   = s1_b[SHW-1:0];
  assign sum     = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff    = {1'b0, s1_a} - {1'b0, s1_b};
  // Extra bit above the MSB / below the LSB captures the last bit shifted out.
  assign shl_w   = {1'b0, s1_a} << shamt;
  assign shr_w   = {s1_a, 1'b0} >> shamt;
  assign add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
  assign sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
  // Overflow direction always follows the sign of operand a.
  assign sat_val = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  always_comb begin
    res_d   = s1_a;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (s1_op)
      OpAdd: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = add_ovf;
      end
      OpSub: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
        ovf_d   = sub_ovf;
      end
      OpAnd:  res_d = s1_a & s1_b;
      OpOr:   res_d = s1_a | s1_b;
      OpXor:  res_d = s1_a ^ s1_b;
      OpShl: begin
        res_d   = shl_w[WIDTH-1:0];
        carry_d = shl_w[WIDTH];
      end
      OpShr: begin
        res_d   = shr_w[WIDTH:1];
        carry_d = shr_w[0];
      end
      OpPass: res_d = s1_a;
      default: res_d = s1_a;
    endcase
`ifdef ALU_PIPE_SAT_EN
    if (ovf_d) begin
      res_d = sat_val;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_op    <= in_op;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid  <= 1'b1;
        out_result <= res_d;
        out_zero   <= (res_d == '0);
        out_neg    <= res_d[WIDTH-1];
        out_carry  <= carry_d;
        out_ovf    <= ovf_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): directed vector table plus
// reset, backpressure and full-throughput sequences against a scoreboard.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero;
  logic        out_neg;
  logic        out_carry;
  logic        out_ovf;

  alu_pipe #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [19:0] exp;  // {result, zero, neg, carry, ovf}
  } vec_t;

  typedef struct {
    logic [19:0] val;
    int          cyc;
  } sb_t;

  vec_t        vecs[17];
  sb_t         exp_q[$];
  logic [19:0] bundle;
  logic [19:0] held;
  logic        stall_prev;
  logic        acc;
  logic        sb_en;
  logic        chk_lat;
  int          cyc;
  int          n_out;
  int          n_block;
  int          n_checks;
  int          n_pass;

  assign bundle = {out_result, out_zero, out_neg, out_carry, out_ovf};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Independent reference using 32-bit integer arithmetic.
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int ua, ub, sa, sb, s, r, c, v, sh;
    logic [31:0] rv;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[3:0]);
    c = 0;
    v = 0;
    s = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 65535) ? 1 : 0; s = sa + sb; end
      3'd1: begin r = ua - ub; c = (ua < ub) ? 1 : 0; s = sa - sb; end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = ua << sh; c = (sh == 0) ? 0 : ((ua >> (16 - sh)) & 1); end
      3'd6: begin r = ua >> sh; c = (sh == 0) ? 0 : ((ua >> (sh - 1)) & 1); end
      default: r = ua;
    endcase
    if (op == 3'd0 || op == 3'd1) v = (s > 32767 || s < -32768) ? 1 : 0;
`ifdef ALU_PIPE_SAT_EN
    if (v != 0) r = (s > 0) ? 32'h7fff : 32'h8000;
`endif
    rv = r;
    return {rv[15:0], rv[15:0] == 16'h0, rv[15], c[0], v[0]};
  endfunction

  // One clock: observe handshakes at negedge, return 1ns after the rising edge.
  task automatic cycle();
    sb_t e;
    @(negedge clk);
    if (stall_prev) check("stall_hold", {12'h0, bundle}, {12'h0, held});
    stall_prev = out_valid && !out_ready;
    held = bundle;
    if (!in_ready) n_block++;
    if (out_valid && out_ready && sb_en) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", {12'h0, bundle}, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", {12'h0, bundle}, {12'h0, e.val});
        if (chk_lat) check("latency", cyc - e.cyc, 2);
      end
    end
    acc = in_valid && in_ready;
    if (acc && sb_en) begin
      e.val = model(in_op, in_a, in_b);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int idx;
    int w;
    n_checks = 0; n_pass = 0; cyc = 0; n_out = 0; n_block = 0;
    stall_prev = 1'b0; sb_en = 1'b0; chk_lat = 1'b0; acc = 1'b0;
    held = '0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;

`ifdef ALU_PIPE_SAT_EN
    vecs[0] = '{3'd0, 16'h7fff, 16'h0001, {16'h7fff, 4'b0001}};
    vecs[8] = '{3'd0, 16'h8000, 16'h8000, {16'h8000, 4'b0111}};
    vecs[9] = '{3'd1, 16'h8000, 16'h0001, {16'h8000, 4'b0101}};
`else
    vecs[0] = '{3'd0, 16'h7fff, 16'h0001, {16'h8000, 4'b0101}};
    vecs[8] = '{3'd0, 16'h8000, 16'h8000, {16'h0000, 4'b1011}};
    vecs[9] = '{3'd1, 16'h8000, 16'h0001, {16'h7fff, 4'b0001}};
`endif
    vecs[1]  = '{3'd1, 16'h0003, 16'h0005, {16'hfffe, 4'b0110}};
    vecs[2]  = '{3'd1, 16'h1234, 16'h1234, {16'h0000, 4'b1000}};
    vecs[3]  = '{3'd5, 16'h8001, 16'h0001, {16'h0002, 4'b0010}};
    vecs[4]  = '{3'd6, 16'h0003, 16'h0001, {16'h0001, 4'b0010}};
    vecs[5]  = '{3'd5, 16'h1234, 16'h0000, {16'h1234, 4'b0000}};
    vecs[6]  = '{3'd6, 16'h8000, 16'h0000, {16'h8000, 4'b0100}};
    vecs[7]  = '{3'd0, 16'hffff, 16'h0001, {16'h0000, 4'b1010}};
    vecs[10] = '{3'd2, 16'hf0f0, 16'h0ff0, {16'h00f0, 4'b0000}};
    vecs[11] = '{3'd3, 16'hf000, 16'h000f, {16'hf00f, 4'b0100}};
    vecs[12] = '{3'd4, 16'haaaa, 16'haaaa, {16'h0000, 4'b1000}};
    vecs[13] = '{3'd7, 16'h8765, 16'hffff, {16'h8765, 4'b0100}};
    vecs[14] = '{3'd5, 16'h0003, 16'h000f, {16'h8000, 4'b0110}};
    vecs[15] = '{3'd6, 16'hc000, 16'h000f, {16'h0001, 4'b0010}};
    vecs[16] = '{3'd5, 16'h4000, 16'h0011, {16'h8000, 4'b0100}};

    // Power-on reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_outputs", {12'h0, bundle}, 0);
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 1);

    // Directed vector table, one beat at a time
    for (int i = 0; i < 17; i++) begin
      in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b; in_valid = 1'b1;
      cycle();
      check($sformatf("vec%0d_accept", i), {31'h0, acc}, 1);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 5) begin
        cycle();
        w++;
      end
      check($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 1);
      check($sformatf("vec%0d_out", i), {12'h0, bundle}, {12'h0, vecs[i].exp});
    end
    cycle();

    // Reset with two beats in flight
    sb_en = 1'b1; exp_q.delete();
    in_valid = 1'b1; in_op = 3'd0; in_a = 16'h0001; in_b = 16'h0002;
    cycle();
    in_a = 16'h0010; in_b = 16'h0020;
    cycle();
    in_valid = 1'b0;
    check("midrst_pre_valid", {31'h0, out_valid}, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 0);
    check("midrst_outputs", {12'h0, bundle}, 0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_out = 0;
    cycle();
    check("midrst_in_ready", {31'h0, in_ready}, 1);
    repeat (4) cycle();
    check("midrst_no_stale", n_out, 0);

    // Backpressure: 10 ADD beats, consumer stalls 4 cycles
    idx = 0; n_out = 0; n_block = 0;
    for (int c = 0; c < 80 && n_out < 10; c++) begin
      in_valid = (idx < 10);
      in_op = 3'd0;
      in_a = 16'h1000 * idx[15:0] + 16'h0fff;
      in_b = 16'h0101 * idx[15:0];
      out_ready = !(c >= 3 && c < 7);
      cycle();
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", n_out, 10);
    check("bp_in_ready_low", n_block, 4);
    check("bp_queue_empty", exp_q.size(), 0);

    // Throughput: 32 random beats, out_ready held high
    n_out = 0; n_block = 0; chk_lat = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_op = 3'($urandom_range(0, 7));
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      cycle();
      check("tput_accept", {31'h0, acc}, 1);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle();
    cycle();
    check("tput_count", n_out, 32);
    check("tput_never_blocked", n_block, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
